// File: rtl/alu4_seq_ctrl.sv
// Command/response sequencer for the 4-bit alu4: issues AND/OR/ADD/SUB and iterated-add MUL.
// Optional ALU4_SEQ_STATS_EN adds an op_count output counting completed responses.
module alu4_seq_ctrl #(
  parameter int DATA_W = 4
`ifdef ALU4_SEQ_STATS_EN
  , parameter int STAT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zf,
  output logic              rsp_cf,
  output logic              rsp_sf,
  output logic              rsp_err,
  output logic [1:0]        alu_ctl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zf,
  input  logic              alu_cf,
  input  logic              alu_sf,
`ifdef ALU4_SEQ_STATS_EN
  output logic [STAT_W-1:0] op_count,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_cnt;
  logic              w_rspDone;

  assign cmd_ready = rst_n & (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_rspDone = rsp_valid & rsp_ready;

  // During MUL, alu_a doubles as the accumulator and alu_b holds the multiplicand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zf    <= 1'b0;
      rsp_cf    <= 1'b0;
      rsp_sf    <= 1'b0;
      rsp_err   <= 1'b0;
      alu_ctl   <= 2'd0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                alu_ctl <= cmd_op[1:0];
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                r_state <= EXEC;
              end
              3'd4: begin
                if (cmd_b != '0) begin
                  alu_ctl <= 2'd2;
                  alu_a   <= '0;
                  alu_b   <= cmd_a;
                  r_cnt   <= cmd_b;
                  r_state <= MUL;
                end else begin
                  rsp_data  <= '0;
                  rsp_zf    <= 1'b1;
                  rsp_cf    <= 1'b0;
                  rsp_sf    <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  r_state   <= RESP;
                end
              end
              default: begin
                rsp_data  <= '0;
                rsp_zf    <= 1'b0;
                rsp_cf    <= 1'b0;
                rsp_sf    <= 1'b0;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                r_state   <= RESP;
              end
            endcase
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_zf    <= alu_zf;
          rsp_cf    <= alu_cf;
          rsp_sf    <= alu_sf;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          alu_ctl   <= 2'd0;
          alu_a     <= '0;
          alu_b     <= '0;
          r_state   <= RESP;
        end
        MUL: begin
          if (r_cnt == DATA_W'(1)) begin
            rsp_data  <= alu_out;
            rsp_zf    <= alu_zf;
            rsp_cf    <= alu_cf;
            rsp_sf    <= alu_sf;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            alu_ctl   <= 2'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            r_state   <= RESP;
          end else begin
            alu_a <= alu_out;
            r_cnt <= r_cnt - DATA_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU4_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count <= '0;
    else if (w_rspDone)
      op_count <= op_count + STAT_W'(1);
  end
`else
  logic w_unusedDone;
  assign w_unusedDone = w_rspDone;
`endif

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Directed self-checking bench for alu4_seq_ctrl; includes a behavioural alu4 model.
module tb_alu4_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_zf;
  logic       rsp_cf;
  logic       rsp_sf;
  logic       rsp_err;
  logic [1:0] alu_ctl;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_out;
  logic       alu_zf;
  logic       alu_cf;
  logic       alu_sf;
  logic       busy;
`ifdef ALU4_SEQ_STATS_EN
  logic [7:0] op_count;
`endif

  int nVectors = 0;
  int nErrors  = 0;
  int lat;
  logic [3:0] heldData;

  alu4_seq_ctrl #(.DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zf(rsp_zf), .rsp_cf(rsp_cf), .rsp_sf(rsp_sf), .rsp_err(rsp_err),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_sf(alu_sf),
`ifdef ALU4_SEQ_STATS_EN
    .op_count(op_count),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference alu4: CF is carry-out on ADD and borrow on SUB.
  logic [4:0] aluWide;
  always_comb begin
    aluWide = 5'd0;
    case (alu_ctl)
      2'd0: aluWide = {1'b0, alu_a & alu_b};
      2'd1: aluWide = {1'b0, alu_a | alu_b};
      2'd2: aluWide = {1'b0, alu_a} + {1'b0, alu_b};
      default: aluWide = {1'b0, alu_a} - {1'b0, alu_b};
    endcase
  end
  assign alu_out = aluWide[3:0];
  assign alu_cf  = aluWide[4];
  assign alu_zf  = (aluWide[3:0] == 4'd0);
  assign alu_sf  = aluWide[3];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one command, lets it be accepted, then counts edges (accept edge = 1) until rsp_valid.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [3:0] a,
                               input logic [3:0] b, output int latency);
    @(negedge clk);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    latency   = 1;
    while (!rsp_valid && latency < 40) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  task automatic completeResp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput({tag, "_vldDrop"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_readyBack"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_a     = 4'd0;
    cmd_b     = 4'd0;
    rsp_ready = 1'b0;
    #12;
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_alu", {22'd0, alu_ctl, alu_a, alu_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);

    applyStimulus("and", 3'd0, 4'hC, 4'hA, lat);
    checkOutput("and_lat", 32'(lat), 32'd2);
    checkOutput("and_data", 32'(rsp_data), 32'h8);
    checkOutput("and_flags", {29'd0, rsp_zf, rsp_sf, rsp_err}, 32'b010);
    checkOutput("and_alu_idle", {22'd0, alu_ctl, alu_a, alu_b}, 32'd0);
    completeResp("and");

    applyStimulus("sub", 3'd3, 4'd3, 4'd5, lat);
    checkOutput("sub_lat", 32'(lat), 32'd2);
    checkOutput("sub_data", 32'(rsp_data), 32'hE);
    checkOutput("sub_flags", {28'd0, rsp_zf, rsp_cf, rsp_sf, rsp_err}, 32'b0110);
    completeResp("sub");

    applyStimulus("add", 3'd2, 4'd8, 4'd8, lat);
    checkOutput("add_data", 32'(rsp_data), 32'h0);
    checkOutput("add_flags", {28'd0, rsp_zf, rsp_cf, rsp_sf, rsp_err}, 32'b1100);
    completeResp("add");

    applyStimulus("or", 3'd1, 4'd5, 4'd2, lat);
    checkOutput("or_data", 32'(rsp_data), 32'h7);
    completeResp("or");

    applyStimulus("mul35", 3'd4, 4'd3, 4'd5, lat);
    checkOutput("mul35_lat", 32'(lat), 32'd6);
    checkOutput("mul35_data", 32'(rsp_data), 32'hF);
    checkOutput("mul35_flags", {28'd0, rsp_zf, rsp_cf, rsp_sf, rsp_err}, 32'b0010);
    completeResp("mul35");

    applyStimulus("mul73", 3'd4, 4'd7, 4'd3, lat);
    checkOutput("mul73_lat", 32'(lat), 32'd4);
    checkOutput("mul73_data", 32'(rsp_data), 32'h5);
    checkOutput("mul73_cf", 32'(rsp_cf), 32'd1);
    completeResp("mul73");

    applyStimulus("mul70", 3'd4, 4'd7, 4'd0, lat);
    checkOutput("mul70_lat", 32'(lat), 32'd1);
    checkOutput("mul70_data", 32'(rsp_data), 32'h0);
    checkOutput("mul70_flags", {28'd0, rsp_zf, rsp_cf, rsp_sf, rsp_err}, 32'b1000);
    completeResp("mul70");

    applyStimulus("ill", 3'd6, 4'hF, 4'hF, lat);
    checkOutput("ill_lat", 32'(lat), 32'd1);
    checkOutput("ill_err", 32'(rsp_err), 32'd1);
    checkOutput("ill_data", {28'd0, rsp_data}, 32'd0);
    checkOutput("ill_flags", {29'd0, rsp_zf, rsp_cf, rsp_sf}, 32'd0);
    checkOutput("ill_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    cmd_op    = 3'd2;
    cmd_a     = 4'd1;
    cmd_b     = 4'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("ill_ignore", {27'd0, rsp_valid, rsp_err, alu_ctl, busy}, 32'b11001);
    completeResp("ill");

    applyStimulus("stall", 3'd2, 4'd6, 4'd7, lat);
    heldData = rsp_data;
    checkOutput("stall_data", 32'(heldData), 32'hD);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_hold", {26'd0, rsp_valid, busy, rsp_data}, {26'd0, 2'b11, heldData});
    end
    completeResp("stall");

    applyStimulus("mulrst", 3'd4, 4'd1, 4'd9, lat);
    checkOutput("mulrst_lat", 32'(lat), 32'd10);
    completeResp("mulrst");
    @(negedge clk);
    cmd_op    = 3'd4;
    cmd_a     = 4'd1;
    cmd_b     = 4'd9;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outs", {24'd0, rsp_valid, busy, cmd_ready, alu_ctl, rsp_err, rsp_zf, rsp_sf}, 32'd0);
    checkOutput("abort_alu", {24'd0, alu_a, alu_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_norsp", 32'(rsp_valid), 32'd0);

    applyStimulus("post", 3'd2, 4'd1, 4'd1, lat);
    checkOutput("post_lat", 32'(lat), 32'd2);
    checkOutput("post_data", 32'(rsp_data), 32'h2);
    completeResp("post");
`ifdef ALU4_SEQ_STATS_EN
    checkOutput("post_count", 32'(op_count), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nErrors);
    $finish;
  end

endmodule
